// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_port_arbiter_if
//  Purpose  : Bundles the fetch, loader and memory-macro signals that pass
//             through imem_port_arbiter.
//  Ports    : AW - word-address width of the instruction memory
//             fetch  : if_addr, redirect -> if_rdata, if_valid, stall_f, stall_d
//             loader : ld_valid, ld_addr, ld_wdata -> ld_ready
//             memory : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//  Modports : slave  - the arbiter itself
//             master - the surrounding pipeline, loader and memory macro
//  Revision : 1.0  initial release
// ============================================================================
interface imem_port_arbiter_if #(
    parameter int AW = 10
);
    // Fetch side
    logic [AW-1:0] if_addr;
    logic          redirect;
    logic [31:0]   if_rdata;
    logic          if_valid;
    logic          stall_f;
    logic          stall_d;
    // Loader / debug write side
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_ready;
    // Memory macro side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_addr, redirect, ld_valid, ld_addr, ld_wdata, mem_rdata,
        output if_rdata, if_valid, stall_f, stall_d, ld_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_addr, redirect, ld_valid, ld_addr, ld_wdata, mem_rdata,
        input  if_rdata, if_valid, stall_f, stall_d, ld_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_port_arbiter
//  Purpose  : Shares a single-port synchronous instruction memory between the
//             fetch stage and a program loader / debug write port. While the
//             loader owns the port, StallF/StallD are raised. A branch
//             redirect kills the fetch whose data returns next cycle.
//  Ports    : clk            rising-edge clock
//             rst_n          asynchronous active-low reset
//             bus            imem_port_arbiter_if.slave (fetch/loader/memory)
//             perf_stall_cnt cycles with stall_f=1      (IMEM_ARB_PERF_EN only)
//             perf_kill_cnt  reads killed by redirect   (IMEM_ARB_PERF_EN only)
//  Params   : AW       word-address width (must match the interface)
//             LD_BURST max consecutive loader grants before a fetch slot (1..15)
//  Config   : define IMEM_ARB_PERF_EN to add the two performance counters
//  Revision : 1.0  initial release
// ============================================================================
module imem_port_arbiter #(
    parameter int AW       = 10,
    parameter int LD_BURST = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    imem_port_arbiter_if.slave   bus
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_kill_cnt
`endif
);

    localparam logic [3:0] c_BURST = 4'(LD_BURST);

    // YIELD drives exactly what FETCH drives; it exists so a burst that hit
    // its grant limit is visibly distinct from a loader that went quiet.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_YIELD = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          rd_pend_q, rd_pend_d;

    logic [3:0]    w_cnt_inc;
    logic          w_mem_en;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [31:0]   w_mem_wdata;
    logic          w_ld_ready;
    logic          w_stall;
    logic          w_rd_issue;

    // ------------------------------------------------------------------
    // Next-state and port steering
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = 4'd0;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = 32'h0;
        w_ld_ready  = 1'b0;
        w_stall     = 1'b0;
        w_cnt_inc   = cnt_q + 4'd1;

        unique case (state_q)
            S_IDLE: begin
                w_stall = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH, S_YIELD: begin
                // A rising ld_valid still gets this fetch slot; the loader is
                // granted the port from the next cycle on.
                w_mem_en   = 1'b1;
                w_mem_addr = bus.if_addr;
                state_d    = bus.ld_valid ? S_LOAD : S_FETCH;
            end
            S_LOAD: begin
                // Every LOAD cycle writes; ld_valid here means another word
                // follows this one.
                w_mem_en    = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = bus.ld_addr;
                w_mem_wdata = bus.ld_wdata;
                w_ld_ready  = 1'b1;
                w_stall     = 1'b1;
                if (!bus.ld_valid) begin
                    state_d = S_FETCH;
                end else if (w_cnt_inc == c_BURST) begin
                    state_d = S_YIELD;
                end else begin
                    state_d = S_LOAD;
                    cnt_d   = w_cnt_inc;
                end
            end
        endcase
    end

    // A read whose cycle also carries a redirect returns a wrong-path word;
    // drop it so IF/ID receives a NOP bubble instead.
    assign w_rd_issue = w_mem_en & ~w_mem_we;

    always_comb begin
        rd_pend_d = w_rd_issue & ~bus.redirect;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.ld_ready  = w_ld_ready;
    assign bus.stall_f   = w_stall;
    assign bus.stall_d   = w_stall;
    assign bus.if_valid  = rd_pend_q;
    assign bus.if_rdata  = rd_pend_q ? bus.mem_rdata : 32'h0;

`ifdef IMEM_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap modulo 2^32)
    // ------------------------------------------------------------------
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_kill_q, perf_kill_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, w_stall};
        perf_kill_d  = perf_kill_q + {31'd0, w_rd_issue & bus.redirect};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= 32'd0;
            perf_kill_q  <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_kill_q  <= perf_kill_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_kill_cnt  = perf_kill_q;
`endif

endmodule
`default_nettype wire
